// File: rtl/instr_mem_sync.sv
// Instruction memory: synchronous RAM image, registered fetch port, runtime program-load port, post-reset init fill.
// Fetch latency 1 cycle from grant; init fill takes DEPTH cycles after reset, during which fetches are refused.
// Backpressure: instr/instr_valid hold while instr_valid & ~instr_ready; no new fetch is granted until consumed.
module instr_mem_sync #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int DEPTH   = 16,
    parameter int OOR_VAL = 50
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              prog_en,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_err,
    output logic              busy
);

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] OOR_L   = DATA_W'(OOR_VAL);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] init_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              running;
    logic              fetch_in_range;
    logic              prog_in_range;
    logic              prog_wr;
    logic              bypass;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;

    assign running        = (state == S_RUN);
    assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_L);
    assign prog_in_range  = ({1'b0, prog_addr} < DEPTH_L);
    assign prog_wr        = running & prog_en & prog_in_range;
    // Write-first: a fetch of the address being programmed this cycle sees the new data
    assign bypass         = prog_wr & (prog_addr == fetch_addr);
    assign fetch_gnt      = running & fetch_req & (~instr_valid | instr_ready);

    // Single write port shared by the init fill and the program-load path
    assign mem_we = rst_n & (~running | prog_wr);
    assign mem_wa = running ? prog_addr : init_ptr;
    assign mem_wd = running ? prog_data : DATA_W'({init_ptr, 1'b0});

    // Storage array: no reset, contents are rebuilt by the init fill
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Init/run sequencer plus registered fetch output and program-error pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_INIT;
            busy        <= 1'b1;
            init_ptr    <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            prog_err    <= 1'b0;
        end else begin
            if (state == S_INIT) begin
                init_ptr <= init_ptr + 1'b1;
                if (init_ptr == LAST_L) begin
                    state <= S_RUN;
                    busy  <= 1'b0;
                end
            end

            prog_err <= prog_en & (~running | ~prog_in_range);

            if (fetch_gnt) begin
                instr_valid <= 1'b1;
                if (!fetch_in_range) begin
                    instr <= OOR_L;
                end else if (bypass) begin
                    instr <= prog_data;
                end else begin
                    instr <= mem[fetch_addr];
                end
            end else if (instr_ready) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed bench for instr_mem_sync: a DEPTH=16 instance (a_*) and a DEPTH=12 instance (b_*) on shared inputs.
// Inputs change 1ns after the rising edge; outputs are checked there too, after registers settle.
// Expected values are hand-computed from the default image (word i = 2*i) and the writes applied.
module tb_instr_mem_sync;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic [3:0]  fetch_addr;
    logic        instr_ready;
    logic        prog_en;
    logic [3:0]  prog_addr;
    logic [15:0] prog_data;

    logic        a_gnt, a_valid, a_prog_err, a_busy;
    logic [15:0] a_instr;
    logic        b_gnt, b_valid, b_prog_err, b_busy;
    logic [15:0] b_instr;

    int total = 0;
    int bad   = 0;
    int n;

    instr_mem_sync #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .OOR_VAL(50)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(a_gnt),
        .instr(a_instr), .instr_valid(a_valid), .instr_ready(instr_ready),
        .prog_en(prog_en), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_err(a_prog_err), .busy(a_busy)
    );

    instr_mem_sync #(.DATA_W(16), .ADDR_W(4), .DEPTH(12), .OOR_VAL(50)) u_dut12 (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(b_gnt),
        .instr(b_instr), .instr_valid(b_valid), .instr_ready(instr_ready),
        .prog_en(prog_en), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_err(b_prog_err), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count cycles until the DEPTH=16 instance leaves init; 40 means it never did
    task automatic wait_busy(output int cnt);
        cnt = 0;
        while (a_busy && cnt < 40) begin
            tick();
            cnt++;
        end
    endtask

    task automatic fetch_one(input logic [3:0] addr);
        fetch_addr  = addr;
        fetch_req   = 1'b1;
        instr_ready = 1'b1;
        tick();
        fetch_req   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0; instr_ready = 1'b0;
        prog_en = 1'b0; prog_addr = '0; prog_data = '0;
        repeat (2) tick();

        // Reset state
        check("rst_instr",  a_instr, 0);
        check("rst_valid",  a_valid, 0);
        check("rst_busy",   a_busy, 1);
        check("rst_perr",   a_prog_err, 0);
        check("rst_busy12", b_busy, 1);

        // Test 1: init length and default image
        rst_n = 1'b1;
        fetch_req = 1'b1;
        #1;
        check("init_gnt", a_gnt, 0);
        fetch_req = 1'b0;
        wait_busy(n);
        check("init_cycles", n, 16);
        check("busy12_done", b_busy, 0);
        for (int i = 0; i < 16; i++) begin
            fetch_addr = 4'(i); fetch_req = 1'b1; instr_ready = 1'b1;
            #1;
            check("t1_gnt", a_gnt, 1);
            tick();
            check("t1_instr", a_instr, 2 * i);
            check("t1_valid", a_valid, 1);
            check("t1_instr12", b_instr, (i < 12) ? 2 * i : 50);
        end
        fetch_req = 1'b0;
        tick();
        check("t1_drain_valid", a_valid, 0);
        check("t1_drain_hold", a_instr, 30);

        // Test 3: stall holds instr; write to held address does not touch it
        fetch_one(4'd3);
        check("t3_first", a_instr, 6);
        instr_ready = 1'b0; fetch_addr = 4'd5; fetch_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t3_stall_gnt", a_gnt, 0);
            if (k == 1) begin
                prog_en = 1'b1; prog_addr = 4'd3; prog_data = 16'h1234;
            end
            tick();
            prog_en = 1'b0;
            check("t3_stall_instr", a_instr, 6);
            check("t3_stall_valid", a_valid, 1);
        end
        instr_ready = 1'b1;
        #1;
        check("t3_release_gnt", a_gnt, 1);
        tick();
        fetch_req = 1'b0;
        check("t3_after", a_instr, 10);

        // Test 4: same-cycle write and fetch of one address is write-first
        fetch_addr = 4'd7; fetch_req = 1'b1;
        prog_en = 1'b1; prog_addr = 4'd7; prog_data = 16'hBEEF;
        tick();
        prog_en = 1'b0; fetch_req = 1'b0;
        check("t4_bypass", a_instr, 16'hBEEF);
        check("t4_bypass12", b_instr, 16'hBEEF);
        fetch_one(4'd0);
        check("t4_word0", a_instr, 0);
        fetch_one(4'd7);
        check("t4_refetch", a_instr, 16'hBEEF);
        fetch_one(4'd3);
        check("t4_stall_write", a_instr, 16'h1234);

        // Test 2: out-of-range handling on the DEPTH=12 instance
        fetch_one(4'd11);
        check("t2_last", b_instr, 22);
        fetch_one(4'd12);
        check("t2_oor12", b_instr, 50);
        fetch_one(4'd15);
        check("t2_oor15", b_instr, 50);
        prog_en = 1'b1; prog_addr = 4'd13; prog_data = 16'h5555;
        tick();
        prog_en = 1'b0;
        check("t2_perr12", b_prog_err, 1);
        check("t2_perr16", a_prog_err, 0);
        tick();
        check("t2_perr_pulse", b_prog_err, 0);
        fetch_one(4'd13);
        check("t2_oor13", b_instr, 50);
        check("t2_w13_16", a_instr, 16'h5555);

        // Test 6: reset in RUN with data held
        fetch_one(4'd7);
        check("t6_pre", a_instr, 16'hBEEF);
        instr_ready = 1'b0;
        tick();
        check("t6_held", a_valid, 1);
        rst_n = 1'b0;
        tick();
        check("t6_instr", a_instr, 0);
        check("t6_valid", a_valid, 0);
        check("t6_busy", a_busy, 1);
        rst_n = 1'b1; instr_ready = 1'b1;

        // Test 5: program write during init is dropped; reset mid-init restarts the fill
        repeat (5) tick();
        prog_en = 1'b1; prog_addr = 4'd2; prog_data = 16'hAAAA;
        tick();
        prog_en = 1'b0;
        check("t5_perr", a_prog_err, 1);
        tick();
        check("t5_perr_pulse", a_prog_err, 0);
        repeat (2) tick();
        check("t5_busy_mid", a_busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_busy(n);
        check("t5_restart_cycles", n, 16);
        fetch_one(4'd2);
        check("t5_word2", a_instr, 4);
        check("t5_word2_12", b_instr, 4);
        fetch_one(4'd7);
        check("t6_word7", a_instr, 14);
        fetch_one(4'd13);
        check("t6_word13", a_instr, 26);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
